// File: rtl/seq_alu.sv
// Registered ALU with start/done handshake and a multi-cycle left shift.
// Define SEQ_ALU_SAT_EN to saturate ADD/SUB/ABS on signed overflow instead of wrapping.
module seq_alu #(
  parameter int WIDTH = 12,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] z,
  output logic             carry_out,
  output logic             sign,
  output logic             ov,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int M  = WIDTH - 1;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ABS = 3'd0;
  localparam logic [2:0] OP_SHL = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_ADD = 3'd6;
  localparam logic [2:0] OP_SUB = 3'd7;

  localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};

`ifdef SEQ_ALU_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef enum logic [0:0] {IDLE, SHIFT} state_t;

  state_t state, state_nxt;

  // Clamp value for an overflowing signed result; neg selects the negative rail.
  function automatic logic [WIDTH-1:0] sat_val(input logic neg);
    return neg ? MIN_V : MAX_V;
  endfunction

  logic                    accept;
  logic                    shift_start;
  logic                    last_step;
  logic [CW-1:0]           n_p0;
  logic [CW-1:0]           cnt;
  logic [WIDTH:0]          sum_p0;
  logic [WIDTH-1:0]        res_p0;
  logic                    c_p0;
  logic                    v_p0;
  logic [WIDTH-1:0]        sh_p1;
  logic                    sh_ov_p1;
  logic [WIDTH-1:0]        sh_next;
  logic                    step_ov;

  assign accept      = start && (state == IDLE);
  assign shift_start = accept && (op == OP_SHL) && (n_p0 != '0);
  assign last_step   = (state == SHIFT) && (cnt == CW'(1));
  assign sh_next     = {sh_p1[M-1:0], 1'b0};
  assign step_ov     = sh_ov_p1 | (sh_p1[M] ^ sh_p1[M-1]);

  // Shift distance clamps at WIDTH; larger values all shift everything out.
  always_comb begin
    if (int'(a[SHW-1:0]) > WIDTH) n_p0 = CW'(WIDTH);
    else                          n_p0 = CW'(a[SHW-1:0]);
  end

  always_comb begin
    sum_p0 = '0;
    res_p0 = '0;
    c_p0   = 1'b0;
    v_p0   = 1'b0;
    case (op)
      OP_ABS: begin
        v_p0   = (a == MIN_V);
        res_p0 = a[M] ? (~a + 1'b1) : a;
        if (SAT && v_p0) res_p0 = sat_val(1'b0);
      end
      OP_SHL: res_p0 = b;
      OP_AND: res_p0 = a & b;
      OP_OR:  res_p0 = a | b;
      OP_XOR: res_p0 = a ^ b;
      OP_NOT: res_p0 = ~a;
      OP_ADD: begin
        sum_p0 = {1'b0, a} + {1'b0, b};
        res_p0 = sum_p0[M:0];
        c_p0   = sum_p0[WIDTH];
        v_p0   = (a[M] == b[M]) && (sum_p0[M] != a[M]);
        if (SAT && v_p0) res_p0 = sat_val(a[M]);
      end
      OP_SUB: begin
        sum_p0 = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        res_p0 = sum_p0[M:0];
        c_p0   = sum_p0[WIDTH];
        v_p0   = (a[M] != b[M]) && (sum_p0[M] != a[M]);
        if (SAT && v_p0) res_p0 = sat_val(a[M]);
      end
      default: res_p0 = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (shift_start) state_nxt = SHIFT;
      SHIFT:   if (cnt == CW'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHIFT);
  end

  // ---- stage p1: shift register, one bit per SHIFT cycle ----
  always_ff @(posedge clk) begin
    if (shift_start) begin
      sh_p1    <= b;
      sh_ov_p1 <= 1'b0;
    end else if (state == SHIFT) begin
      sh_p1    <= sh_next;
      sh_ov_p1 <= step_ov;
    end
  end

  // ---- output stage: result, flags and done pulse ----
  always_ff @(posedge clk) begin
    if (rst) begin
      z         <= '0;
      carry_out <= 1'b0;
      sign      <= 1'b0;
      ov        <= 1'b0;
      zero      <= 1'b1;
      done      <= 1'b0;
      cnt       <= '0;
    end else begin
      done <= 1'b0;
      if (accept && !shift_start) begin
        z         <= res_p0;
        carry_out <= c_p0;
        ov        <= v_p0;
        sign      <= res_p0[M];
        zero      <= (res_p0 == '0);
        done      <= 1'b1;
      end else if (last_step) begin
        z         <= sh_next;
        carry_out <= sh_p1[M];
        ov        <= step_ov;
        sign      <= sh_next[M];
        zero      <= (sh_next == '0);
        done      <= 1'b1;
      end
      if (shift_start)         cnt <= n_p0;
      else if (state == SHIFT) cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Randomized bench for seq_alu (WIDTH=12) against an arithmetic reference model.
// Honors SEQ_ALU_SAT_EN when compiled with the same define as the design.
module tb_seq_alu;
  localparam int W    = 12;
  localparam int MASK = 4095;
  localparam int MINV = 2048;
  localparam int MAXV = 2047;
`ifdef SEQ_ALU_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] z;
  logic         carry_out, sign, ov, zero, busy, done;

  int checks   = 0;
  int failures = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .z(z), .carry_out(carry_out), .sign(sign), .ov(ov), .zero(zero),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int sval(input int v);
    return (v >= MINV) ? v - 4096 : v;
  endfunction

  // Expected result, carry, overflow, done latency and busy-cycle count.
  task automatic model(input int mop, input int ma, input int mb,
                       output int ez, output int ec, output int ev,
                       output int elat, output int enb);
    int n, x, win, full, ss;
    ez = 0; ec = 0; ev = 0; elat = 1; enb = 0; ss = 0;
    case (mop)
      0: begin
        if (ma == MINV) begin ev = 1; ez = SAT ? MAXV : MINV; end
        else ez = (ma >= MINV) ? 4096 - ma : ma;
      end
      1: begin
        n = ma & 15;
        if (n > W) n = W;
        ez = (mb << n) & MASK;
        if (n > 0) ec = (mb >> (W - n)) & 1;
        x    = mb << 1;
        full = (1 << (n + 1)) - 1;
        win  = (x >> (W - n)) & full;
        ev   = (win != 0 && win != full) ? 1 : 0;
        elat = n + 1;
        enb  = n;
      end
      2: ez = ma & mb;
      3: ez = ma | mb;
      4: ez = ma ^ mb;
      5: ez = (~ma) & MASK;
      6: begin
        ez = (ma + mb) & MASK;
        ec = (ma + mb) >> W;
        ss = sval(ma) + sval(mb);
      end
      default: begin
        ez = (ma - mb) & MASK;
        ec = (ma >= mb) ? 1 : 0;
        ss = sval(ma) - sval(mb);
      end
    endcase
    if (mop >= 6) begin
      ev = (ss > MAXV || ss < -MINV) ? 1 : 0;
      if (SAT && ev == 1) ez = (ss > 0) ? MAXV : MINV;
    end
  endtask

  task automatic wait_done(inout int lat, inout int nb);
    while (done !== 1'b1 && lat < 40) begin
      if (busy) nb++;
      step();
      lat++;
    end
    if (busy) nb++;
  endtask

  task automatic check_result(input string tag, input int ez, input int ec, input int ev);
    check({tag, ".z"}, int'(z), ez);
    check({tag, ".carry"}, int'(carry_out), ec);
    check({tag, ".ov"}, int'(ov), ev);
    check({tag, ".sign"}, int'(sign), (ez >> (W - 1)) & 1);
    check({tag, ".zero"}, int'(zero), (ez == 0) ? 1 : 0);
  endtask

  task automatic run_op(input int mop, input int ma, input int mb, input string tag);
    int ez, ec, ev, elat, enb, lat, nb;
    model(mop, ma, mb, ez, ec, ev, elat, enb);
    op = 3'(mop); a = W'(ma); b = W'(mb); start = 1'b1;
    step();
    start = 1'b0;
    lat = 1; nb = 0;
    wait_done(lat, nb);
    check({tag, ".lat"}, lat, elat);
    check({tag, ".busy"}, nb, enb);
    check_result(tag, ez, ec, ev);
    step();
    check({tag, ".pulse"}, int'(done), 0);
    check({tag, ".hold"}, int'(z), ez);
  endtask

  initial begin
    int ez, ec, ev, elat, enb, lat, nb, seen, ma, mb;
    int edges [4] = '{0, 2047, 2048, 4095};

    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    step();
    step();
    check("rst.z", int'(z), 0);
    check("rst.zero", int'(zero), 1);
    check("rst.done", int'(done), 0);
    check("rst.busy", int'(busy), 0);
    check("rst.flags", int'({carry_out, sign, ov}), 0);
    rst = 1'b0;
    step();

    run_op(6, 'h7FF, 'h001, "add_ovf");
    run_op(7, 'h005, 'h007, "sub_borrow");
    run_op(7, 'h123, 'h123, "sub_equal");
    run_op(0, 'h800, 'h000, "abs_min");
    run_op(0, 'hFFB, 'h000, "abs_neg");
    run_op(1, 5, 'h003, "shl_5");
    run_op(1, 2, 'hC00, "shl_out");
    run_op(1, 15, 'h5A5, "shl_clamp");
    run_op(1, 0, 'h9A5, "shl_zero");
    run_op(5, 'h0F0, 'h000, "not");

    // Start pulsed mid-shift must be dropped.
    model(1, 8, 'h015, ez, ec, ev, elat, enb);
    op = 3'd1; a = W'(8); b = W'('h015); start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    op = 3'd6; a = W'(1); b = W'(2); start = 1'b1;
    step();
    start = 1'b0;
    lat = 4; nb = 3;
    wait_done(lat, nb);
    check("ignore.lat", lat, elat);
    check_result("ignore", ez, ec, ev);
    step();
    check("ignore.nodone", int'(done), 0);

    // Start held through the shift's done cycle is accepted there.
    model(1, 3, 'h101, ez, ec, ev, elat, enb);
    op = 3'd1; a = W'(3); b = W'('h101); start = 1'b1;
    step();
    op = 3'd6; a = W'('h100); b = W'('h023);
    lat = 1; nb = 0;
    wait_done(lat, nb);
    check("b2b.shl_lat", lat, elat);
    check_result("b2b.shl", ez, ec, ev);
    step();
    start = 1'b0;
    check("b2b.add_done", int'(done), 1);
    check_result("b2b.add", 'h123, 0, 0);
    step();
    check("b2b.pulse", int'(done), 0);

    // Reset in the middle of a shift aborts it silently.
    op = 3'd1; a = W'(8); b = W'('hABC); start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort.busy", int'(busy), 0);
    check("abort.z", int'(z), 0);
    check("abort.zero", int'(zero), 1);
    check("abort.done", int'(done), 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done) seen = 1;
    end
    check("abort.nodone", seen, 0);
    run_op(2, 'hF0F, 'h0FF, "and_after_rst");

    for (int i = 0; i < 200; i++) begin
      ma = (i % 4 == 0) ? edges[$urandom_range(0, 3)] : int'($urandom & MASK);
      mb = (i % 5 == 0) ? edges[$urandom_range(0, 3)] : int'($urandom & MASK);
      run_op(int'($urandom_range(0, 7)), ma, mb, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, registered ALU with a start/done handshake. It supersedes the fixed-width combinational ALU and keeps the same 3-bit opcode map. It adds registered flags (carry, sign, overflow, zero) and a multi-cycle variable-distance left shift. It sits between the register file and the result bus; the controller issues one operation at a time and waits for `done`.

Parameters:
WIDTH, 12, operand/result width in bits (>=4).
SHW, $clog2(WIDTH), width of shift-amount field taken from A[SHW-1:0].

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request; accepted only when FSM in IDLE.
op  input  3  operation select, latched on accept.
a  input  WIDTH  operand A, latched on accept.
b  input  WIDTH  operand B, latched on accept.
z  output  WIDTH  registered result.
carry_out  output  1  registered carry / no-borrow / last bit shifted out.
sign  output  1  registered z[WIDTH-1].
ov  output  1  registered signed-overflow flag.
zero  output  1  registered (z == 0).
busy  output  1  high while a multi-cycle shift is in progress.
done  output  1  one-cycle pulse: z and flags valid and updated this cycle.

Behaviour:
- Reset (clk edge with rst=1): state=IDLE; z, carry_out, sign, ov, busy, done all 0; zero=1. Reset mid-shift aborts the operation with no done pulse.
- FSM states: IDLE, SHIFT.
- Accept: start=1 in IDLE at edge T latches op, a and b.
- Single-cycle ops (op != 1): results registered at T+1, done=1 at T+1, state stays IDLE.
- Shift (op=1): n = min(a[SHW-1:0], WIDTH).
  - n=0: z=b, carry_out=0, ov=0, done at T+1.
  - n>0: go to SHIFT; busy=1 for cycles T+1..T+n; b shifts left one bit per cycle.
  - done at T+1+n with busy=0; return to IDLE.
- start while busy is ignored (not queued).
- start on a done cycle is accepted, because the FSM is in IDLE that cycle.
- Outputs hold their values between done pulses. done is 0 otherwise.
- Opcodes (M = WIDTH-1):
  - 0 ABS: z = a[M] ? -a : a. ov=1 only when a = 100..0 (then z = a). carry_out=0.
  - 1 SHL: z = b << n. carry_out = last bit shifted out. ov=1 if z[M] changed on any step.
  - 2 AND, 3 OR, 4 XOR: z = a op b. 5 NOT: z = ~a. For ops 2-5, carry_out=0 and ov=0.
  - 6 ADD: {carry_out,z} = a + b (WIDTH+1 bits). ov = (a[M]==b[M]) && (z[M]!=a[M]).
  - 7 SUB: {carry_out,z} = a + ~b + 1. carry_out=1 means no borrow (a >= b unsigned). ov = (a[M]!=b[M]) && (z[M]!=a[M]).
- sign and zero are always derived from the final z, registered in the same cycle as z.

Optional Feature:
Macro SEQ_ALU_SAT_EN.
- Defined: ADD, SUB and ABS saturate on overflow. Positive overflow gives z = 011..1; negative overflow gives z = 100..0. ABS of 100..0 gives 011..1. ov still reports 1. sign and zero follow the saturated z. carry_out is unchanged (raw carry).
- Undefined: results wrap as specified above.

Test Plan (WIDTH=12):
1. ADD a=0x7FF, b=0x001, start at T -> done at T+1; z=0x800, ov=1, carry_out=0, sign=1, zero=0. With SEQ_ALU_SAT_EN: z=0x7FF, ov=1.
2. SUB a=0x005, b=0x007 -> z=0xFFE, carry_out=0, sign=1, ov=0. SUB a=0x123, b=0x123 -> z=0, carry_out=1, zero=1.
3. ABS a=0x800 -> z=0x800, ov=1 (0x7FF with SEQ_ALU_SAT_EN). ABS a=0xFFB -> z=0x005, ov=0.
4. SHL b=0x003, a=5 -> busy 5 cycles, done at T+6, z=0x060, carry_out=0, ov=0. SHL b=0xC00, a=2 -> z=0x000, carry_out=1, ov=1, zero=1. SHL a=15 -> clamped to n=12, z=0, done at T+13.
5. During a shift (a=8), pulse start with ADD -> ignored; shift result appears at T+9. start held high across that done -> ADD accepted on the done cycle, its done follows 1 cycle later.
6. Assert rst at T+3 of an 8-cycle shift -> next cycle busy=0, done never pulses, z=0, zero=1. A new AND (0xF0F & 0x0FF) -> z=0x00F at the following cycle.
